if_id_hazard_ctrl: RTL and testbench
====================================

# if_id_hazard_ctrl

Pipeline sequencing controller for the IF/ID pipeline register and PC. It decides each cycle whether the PC advances or takes a redirect, and whether the IF/ID register captures, holds, or is flushed to a NOP. It also decides whether the ID/EX register gets a bubble. Inputs are load-use hazards, taken branches resolved in EX, and instruction-memory wait states. It sits beside the fetch/decode boundary and drives the enable/flush controls of the PC register, IF/ID and ID/EX.

## Interface
- PC_W, 12, PC/target width
- REG_W, 5, register index width
- CNT_W, 16, width of the performance counters
- FLUSH_CYCLES, 1, extra IF/ID flush cycles after a redirect (legal 1..3)

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_target  in  PC_W  redirect target from EX
- imem_ready  in  1  fetched instruction valid this cycle
- pc_en  out  1  PC register update enable
- pc_sel  out  1  0 = sequential PC, 1 = pc_target
- pc_target  out  PC_W  redirect PC
- if_id_en  out  1  IF/ID capture enable (0 = hold)
- if_id_flush  out  1  IF/ID loads NOP 32'h00000013, overrides if_id_en
- id_ex_bubble  out  1  ID/EX loads a bubble
- ctrl_state  out  2  current FSM state encoding
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

## Operation
- Outputs are Mealy: combinational from FSM state, the pending register and the inputs. Counters and state are registered.
- Load-use hazard (lu): ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2)).
- States: RUN (2'd0), REDIR (2'd1), IWAIT (2'd2).
- **RUN, priority order:**
  1. ex_branch_taken && imem_ready: pc_sel=1, pc_target=ex_target, pc_en=1, if_id_flush=1, id_ex_bubble=1. Load redir_cnt=FLUSH_CYCLES. Next state REDIR.
  2. ex_branch_taken && !imem_ready: latch pend_target=ex_target, pend=1. pc_en=0, if_id_flush=1, id_ex_bubble=1. Next state IWAIT.
  3. lu: pc_en=0, if_id_en=0, id_ex_bubble=1. Stay in RUN. The stall applies regardless of imem_ready.
  4. !imem_ready: pc_en=0, if_id_flush=1. Next state IWAIT.
  5. Otherwise: pc_en=1, if_id_en=1, pc_sel=0.
- **REDIR:**
  - pc_en = imem_ready.
  - if_id_flush=1.
  - lu and ex_branch_taken are ignored, because EX holds a bubble.
  - Decrement redir_cnt. Go to RUN when it reaches 0.
  - If !imem_ready at exit, go to IWAIT instead.
- **IWAIT:**
  - lu is masked.
  - ex_branch_taken is ignored, because EX holds a bubble.
  - While !imem_ready: pc_en=0, if_id_flush=1.
  - On imem_ready with pend=1: act as RUN case 1, using pend_target, then clear pend.
  - On imem_ready with pend=0: pc_en=1, if_id_en=1. Next state RUN.
- pc_target = pend_target when driving a pending redirect, otherwise ex_target.
- **Counters:**
  - stall_cnt increments each cycle with pc_en==0.
  - flush_cnt increments each cycle with if_id_flush==1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=RUN, pend=0, pend_target=0, redir_cnt=0, both counters 0.
  - While reset is asserted, outputs are forced: pc_en=0, pc_sel=0, pc_target=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, ctrl_state=0.
- Reset mid-IWAIT discards any pending redirect.
- Redirect latency: the target is applied in the same cycle as ex_branch_taken, or in the first imem_ready cycle if pending.
- IF/ID is then flushed for 1+FLUSH_CYCLES consecutive cycles.
- A load-use stall lasts exactly one cycle per hazard. It clears once the bubble reaches EX.
- Simultaneous lu and ex_branch_taken: the branch wins, and no stall is counted beyond pc_en.

## Structure
- Package pipe_ctrl_pkg holds:
  - ctrl_state_e enum (RUN, REDIR, IWAIT)
  - NOP_INSTR constant 32'h00000013
  - typedef pipe_ctrl_t {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble}
- One sub-module, sat_counter #(W): increment enable, async active-low clear, saturating. Instantiated twice.

## Test plan
- Reset applied mid-stream -> all outputs take their reset values asynchronously; both counters read 0 after release.
- ex_mem_read=1, ex_rd=5, id_rs1=5, imem_ready=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt=1.
- ex_rd=0 with a matching load, or id_uses_rs2=0 with only an rs2 match -> no stall.
- ex_branch_taken=1, ex_target=12'h040, FLUSH_CYCLES=1 -> same cycle pc_sel=1, pc_target=12'h040, if_id_flush=1. Next cycle REDIR with flush. Then RUN; flush_cnt=2.
- Branch with imem_ready=0 held for 3 cycles, target 12'h100 -> IWAIT, pc_en=0. On ready, pc_sel=1 and pc_target=12'h100 in that cycle, pend cleared.
- Force imem_ready=0 for 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones and does not wrap.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    IWAIT = 2'd2
  } ctrl_state_e;

  // Instruction loaded into IF/ID when it is flushed (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_bubble;
  } pipe_ctrl_t;

  // Controls driven while the pipeline is held in reset.
  function automatic pipe_ctrl_t reset_ctrl();
    pipe_ctrl_t c;
    c.pc_en        = 1'b0;
    c.pc_sel       = 1'b0;
    c.if_id_en     = 1'b0;
    c.if_id_flush  = 1'b1;
    c.id_ex_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already pinned at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// Sequencing control for PC, IF/ID and ID/EX: branch redirects,
// load-use stalls and instruction-memory wait states.
module if_id_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W         = 12,
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_target,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  ctrl_state_e      state_q, state_d;
  logic             pend_q, pend_d;
  logic [PC_W-1:0]  pend_target_q, pend_target_d;
  logic [1:0]       redir_cnt_q, redir_cnt_d;
  pipe_ctrl_t       ctrl;
  logic [PC_W-1:0]  target;
  logic             lu;

  // Load in EX writes a register that the ID instruction reads.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // State, pending redirect and flush countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      redir_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      redir_cnt_q   <= redir_cnt_d;
    end
  end

  // Next-state and Mealy pipeline controls.
  always_comb begin
    ctrl          = '0;
    target        = ex_target;
    state_d       = state_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    redir_cnt_d   = redir_cnt_q;
    unique case (state_q)
      RUN: begin
        if (ex_branch_taken && imem_ready) begin
          ctrl.pc_en        = 1'b1;
          ctrl.pc_sel       = 1'b1;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          redir_cnt_d       = FLUSH_LOAD;
          state_d           = REDIR;
        end else if (ex_branch_taken) begin
          // Fetch is stalled: remember where to go once memory responds.
          pend_d            = 1'b1;
          pend_target_d     = ex_target;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          state_d           = IWAIT;
        end else if (lu) begin
          ctrl.id_ex_bubble = 1'b1;
        end else if (!imem_ready) begin
          ctrl.if_id_flush = 1'b1;
          state_d          = IWAIT;
        end else begin
          ctrl.pc_en    = 1'b1;
          ctrl.if_id_en = 1'b1;
        end
      end
      REDIR: begin
        // EX holds a bubble here, so hazards and branches are ignored.
        ctrl.pc_en       = imem_ready;
        ctrl.if_id_flush = 1'b1;
        redir_cnt_d      = redir_cnt_q - 2'd1;
        if (redir_cnt_q <= 2'd1) begin
          state_d = imem_ready ? RUN : IWAIT;
        end
      end
      IWAIT: begin
        if (!imem_ready) begin
          ctrl.if_id_flush = 1'b1;
        end else if (pend_q) begin
          ctrl.pc_en        = 1'b1;
          ctrl.pc_sel       = 1'b1;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          target            = pend_target_q;
          pend_d            = 1'b0;
          redir_cnt_d       = FLUSH_LOAD;
          state_d           = REDIR;
        end else begin
          ctrl.pc_en    = 1'b1;
          ctrl.if_id_en = 1'b1;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Hold the pipeline quiescent for as long as reset is asserted.
    if (!rst_n) begin
      ctrl   = reset_ctrl();
      target = '0;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign pc_sel       = ctrl.pc_sel;
  assign pc_target    = target;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ctrl_state   = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctrl.pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench for if_id_hazard_ctrl with an expectation queue and
// a saturating counter model.
module tb_if_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready;
  logic [11:0] ex_target;
  logic        pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble;
  logic [11:0] pc_target;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        pe;
    logic        ps;
    logic [11:0] pt;
    logic        ie;
    logic        fl;
    logic        bb;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] m_stall = '0;
  logic [15:0] m_flush = '0;

  always #5 clk = ~clk;

  if_id_hazard_ctrl #(.PC_W(12), .REG_W(5), .CNT_W(16), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
    .imem_ready(imem_ready),
    .pc_en(pc_en), .pc_sel(pc_sel), .pc_target(pc_target),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [15:0] sat_inc(logic [15:0] v, bit en);
    if (en && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected controls, compare at negedge.
  task automatic step(input string tag,
                      input bit br, input logic [11:0] tgt, input bit rdy,
                      input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input bit u2,
                      input bit pe, input bit ps, input logic [11:0] pt,
                      input bit ie, input bit fl, input bit bb, input logic [1:0] st);
    exp_t e;
    ex_branch_taken = br; ex_target = tgt; imem_ready = rdy;
    ex_mem_read = mr; ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2;
    exp_q.push_back('{pe: pe, ps: ps, pt: pt, ie: ie, fl: fl, bb: bb, st: st});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(e.pe));
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(e.ps));
    chk({tag, ".pc_target"}, 32'(pc_target), 32'(e.pt));
    chk({tag, ".if_id_en"}, 32'(if_id_en), 32'(e.ie));
    chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e.fl));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e.bb));
    chk({tag, ".ctrl_state"}, 32'(ctrl_state), 32'(e.st));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    $display("step %-10s pc_en=%0b pc_sel=%0b tgt=%03h if_id_en=%0b flush=%0b bubble=%0b st=%0d stall=%0d flushes=%0d",
             tag, pc_en, pc_sel, pc_target, if_id_en, if_id_flush, id_ex_bubble,
             ctrl_state, stall_cnt, flush_cnt);
    m_stall = sat_inc(m_stall, !e.pe);
    m_flush = sat_inc(m_flush, e.fl);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".pc_en"}, 32'(pc_en), 32'd0);
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'd0);
    chk({tag, ".pc_target"}, 32'(pc_target), 32'd0);
    chk({tag, ".if_id_en"}, 32'(if_id_en), 32'd0);
    chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'd1);
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'd1);
    chk({tag, ".ctrl_state"}, 32'(ctrl_state), 32'd0);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'd0);
    $display("reset %s outputs pc_en=%0b flush=%0b bubble=%0b stall=%0d flushes=%0d",
             tag, pc_en, if_id_flush, id_ex_bubble, stall_cnt, flush_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_branch_taken = 1'b0; ex_target = 12'h055; imem_ready = 1'b1;
    ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
    #3;
    chk_reset_outputs("por");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    //    tag          br tgt     rdy mr rd r1 r2 u2   pe ps pt      ie fl bb st
    step("run",        0, 12'h010, 1, 0, 0, 1, 2, 1,  1, 0, 12'h010, 1, 0, 0, 2'd0);
    step("lu_rs1",     0, 12'h011, 1, 1, 5, 5, 2, 1,  0, 0, 12'h011, 0, 0, 1, 2'd0);
    step("lu_clear",   0, 12'h012, 1, 0, 5, 5, 2, 1,  1, 0, 12'h012, 1, 0, 0, 2'd0);
    step("rd_zero",    0, 12'h013, 1, 1, 0, 0, 0, 1,  1, 0, 12'h013, 1, 0, 0, 2'd0);
    step("rs2_nouse",  0, 12'h014, 1, 1, 7, 3, 7, 0,  1, 0, 12'h014, 1, 0, 0, 2'd0);
    step("lu_rs2",     0, 12'h015, 1, 1, 7, 3, 7, 1,  0, 0, 12'h015, 0, 0, 1, 2'd0);
    step("lu_nordy",   0, 12'h016, 0, 1, 9, 9, 0, 0,  0, 0, 12'h016, 0, 0, 1, 2'd0);
    step("br_lu",      1, 12'h040, 1, 1, 5, 5, 0, 0,  1, 1, 12'h040, 0, 1, 1, 2'd0);
    step("redir",      1, 12'h077, 1, 1, 5, 5, 0, 0,  1, 0, 12'h077, 0, 1, 0, 2'd1);
    step("run2",       0, 12'h018, 1, 0, 0, 0, 0, 0,  1, 0, 12'h018, 1, 0, 0, 2'd0);
    step("br_wait",    1, 12'h100, 0, 0, 0, 0, 0, 0,  0, 0, 12'h100, 0, 1, 1, 2'd0);
    step("iwait1",     1, 12'h0AA, 0, 1, 5, 5, 0, 0,  0, 0, 12'h0AA, 0, 1, 0, 2'd2);
    step("iwait2",     1, 12'h0AA, 0, 1, 5, 5, 0, 0,  0, 0, 12'h0AA, 0, 1, 0, 2'd2);
    step("pend_go",    0, 12'h0AA, 1, 0, 0, 0, 0, 0,  1, 1, 12'h100, 0, 1, 1, 2'd2);
    step("redir_nr",   0, 12'h019, 0, 0, 0, 0, 0, 0,  0, 0, 12'h019, 0, 1, 0, 2'd1);
    step("iwait_lu",   0, 12'h01A, 1, 1, 5, 5, 0, 0,  1, 0, 12'h01A, 1, 0, 0, 2'd2);
    step("run3",       0, 12'h01B, 1, 0, 0, 0, 0, 0,  1, 0, 12'h01B, 1, 0, 0, 2'd0);
    step("nordy",      0, 12'h01C, 0, 0, 0, 0, 0, 0,  0, 0, 12'h01C, 0, 1, 0, 2'd0);
    step("iwait_go",   0, 12'h01D, 1, 0, 0, 0, 0, 0,  1, 0, 12'h01D, 1, 0, 0, 2'd2);
    step("br_pend",    1, 12'h200, 0, 0, 0, 0, 0, 0,  0, 0, 12'h200, 0, 1, 1, 2'd0);

    // Asynchronous reset in IWAIT with a redirect pending.
    ex_branch_taken = 1'b0; ex_target = 12'h033; imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    m_stall = '0;
    m_flush = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // The post-reset cycle clocked with imem_ready low: one stall, one flush.
    m_stall = 16'd1;
    m_flush = 16'd1;
    step("post_rst",   0, 12'h033, 0, 0, 0, 0, 0, 0,  0, 0, 12'h033, 0, 1, 0, 2'd2);
    step("no_pend",    0, 12'h034, 1, 0, 0, 0, 0, 0,  1, 0, 12'h034, 1, 0, 0, 2'd2);
    step("run4",       0, 12'h035, 1, 0, 0, 0, 0, 0,  1, 0, 12'h035, 1, 0, 0, 2'd0);

    // Long memory wait to drive both counters into saturation.
    imem_ready = 1'b0;
    ex_target = 12'h036;
    for (int i = 0; i < 65541; i++) begin
      @(posedge clk);
      m_stall = sat_inc(m_stall, 1'b1);
      m_flush = sat_inc(m_flush, 1'b1);
    end
    #1;
    step("saturated",  0, 12'h036, 0, 0, 0, 0, 0, 0,  0, 0, 12'h036, 0, 1, 0, 2'd2);
    chk("sat.stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat.flush_cnt", 32'(flush_cnt), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hang in case the clocking loop misbehaves.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
